// File: rtl/rotating_square_generator_n.sv
// Purpose: animates a square glyph around an N-digit active-low common-anode display, with digit scan mux.
// Latency: an_o/sseg_o are registered one cycle after (scan index, pos); pos_o/step_o change on the step edge.
// Backpressure: none; en_i freezes the animation (step counter held), the scan keeps running.
module rotating_square_generator_n #(
    parameter int         NUM_DIGITS     = 4,
    parameter int         STEP_PERIOD    = 12_500_000,
    parameter int         SCAN_PERIOD    = 100_000,
    parameter logic [6:0] TOP_PATTERN    = 7'b0011100,
    parameter logic [6:0] BOTTOM_PATTERN = 7'b1100010
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic                              dir_i,
    output logic [NUM_DIGITS-1:0]             an_o,
    output logic [6:0]                        sseg_o,
    output logic                              step_o,
    output logic [$clog2(2*NUM_DIGITS)-1:0]   pos_o
);

    localparam int P  = 2 * NUM_DIGITS;
    localparam int PW = $clog2(P);
    localparam int SW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIOD - 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(P - 1);

    logic [SW-1:0] step_cnt;
    logic [CW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;

    logic [31:0]   pos_ext;
    logic [31:0]   glyph_digit;
    logic [6:0]    glyph;
    logic          hit;

    // Step timer: counts only while enabled; a wrap advances pos and pulses step_o for one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_cnt <= '0;
            step_o   <= 1'b0;
            pos_o    <= '0;
        end else if (en_i) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                step_o   <= 1'b1;
                if (!dir_i) begin
                    pos_o <= (pos_o == POS_LAST) ? '0 : pos_o + 1'b1;
                end else begin
                    pos_o <= (pos_o == '0) ? POS_LAST : pos_o - 1'b1;
                end
            end else begin
                step_cnt <= step_cnt + 1'b1;
                step_o   <= 1'b0;
            end
        end else begin
            step_o <= 1'b0;
        end
    end

    // Digit scan: free-running, independent of en_i, so the display never goes dark while paused.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Map pos to the digit carrying the square: top half runs left to right, bottom half right to left.
    always_comb begin
        pos_ext     = 32'(pos_o);
        glyph_digit = '0;
        glyph       = TOP_PATTERN;
        if (pos_ext < NUM_DIGITS) begin
            glyph_digit = NUM_DIGITS - 1 - pos_ext;
            glyph       = TOP_PATTERN;
        end else begin
            glyph_digit = pos_ext - NUM_DIGITS;
            glyph       = BOTTOM_PATTERN;
        end
        hit = (32'(scan_idx) == glyph_digit);
    end

    // Registered display drive: one enable low for the scanned digit, glyph only where the square sits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_o   <= '1;
            sseg_o <= 7'h7F;
        end else begin
            an_o   <= ~(NUM_DIGITS'(1) << scan_idx);
            sseg_o <= hit ? glyph : 7'h7F;
        end
    end

endmodule

// File: tb/tb_rotating_square_generator_n.sv
module tb_rotating_square_generator_n;

    localparam logic [6:0] TOP = 7'b0011100;
    localparam logic [6:0] BOT = 7'b1100010;
    localparam logic [6:0] BLANK = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;

    logic [3:0] an_a;
    logic [6:0] sseg_a;
    logic       step_a;
    logic [2:0] pos_a;

    logic [5:0] an_b;
    logic [6:0] sseg_b;
    logic       step_b;
    logic [3:0] pos_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rotating_square_generator_n #(
        .NUM_DIGITS(4), .STEP_PERIOD(4), .SCAN_PERIOD(1),
        .TOP_PATTERN(TOP), .BOTTOM_PATTERN(BOT)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir),
        .an_o(an_a), .sseg_o(sseg_a), .step_o(step_a), .pos_o(pos_a)
    );

    rotating_square_generator_n #(
        .NUM_DIGITS(6), .STEP_PERIOD(1), .SCAN_PERIOD(3),
        .TOP_PATTERN(TOP), .BOTTOM_PATTERN(BOT)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir),
        .an_o(an_b), .sseg_o(sseg_b), .step_o(step_b), .pos_o(pos_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected one-hot-low enable for an N-digit display scanning digit d.
    function automatic logic [31:0] exp_an(input int n, input int d);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        v[d] = 1'b0;
        return v;
    endfunction

    // Expected segments for an N-digit display showing position p while digit d is scanned.
    function automatic logic [6:0] exp_seg(input int n, input int p, input int d);
        int g;
        g = (p < n) ? (n - 1 - p) : (p - n);
        if (g != d) return BLANK;
        return (p < n) ? TOP : BOT;
    endfunction

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        dir = 1'b0;

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk("rst_an", an_a, 4'hF);
        chk("rst_sseg", sseg_a, BLANK);
        chk("rst_pos", pos_a, 0);
        chk("rst_step", step_a, 0);
        chk("rst_an_b", an_b, 6'h3F);
        repeat (2) tick();
        rst = 1'b0;

        // Forward sequence, edges k = 1..32 after release
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("fwd_pos", pos_a, (k / 4) % 8);
            chk("fwd_step", step_a, (k % 4) == 0);
            chk("fwd_an", an_a, exp_an(4, (k - 1) % 4));
            chk("fwd_sseg", sseg_a, exp_seg(4, ((k - 1) / 4) % 8, (k - 1) % 4));
            if (k == 4) begin
                chk("pos0_an", an_a, 4'b0111);
                chk("pos0_sseg", sseg_a, 7'b0011100);
            end
            if (k == 17) begin
                chk("pos4_an", an_a, 4'b1110);
                chk("pos4_sseg", sseg_a, 7'b1100010);
            end
        end

        // Reverse from pos 0 wraps to 7
        dir = 1'b1;
        repeat (3) tick();
        chk("rev_hold", pos_a, 0);
        tick();                                 // k = 36
        chk("rev_wrap_pos", pos_a, 7);
        chk("rev_wrap_step", step_a, 1);
        tick();                                 // k = 37
        chk("rev_an_d0", an_a, 4'b1110);
        chk("rev_sseg_d0", sseg_a, BLANK);
        dir = 1'b0;
        tick();                                 // k = 38
        chk("dir_mid1", pos_a, 7);
        dir = 1'b1;
        tick();                                 // k = 39
        chk("dir_mid2", pos_a, 7);
        chk("dir_mid_step", step_a, 0);
        tick();                                 // k = 40
        chk("dir_step_pos", pos_a, 6);
        chk("dir_step_pulse", step_a, 1);
        chk("pos7_an", an_a, 4'b0111);
        chk("pos7_sseg", sseg_a, BOT);

        // Pause with the step counter at 2
        repeat (2) tick();                      // k = 42
        en = 1'b0;
        for (int k = 43; k <= 52; k++) begin
            tick();
            chk("pause_step", step_a, 0);
            chk("pause_pos", pos_a, 6);
            chk("pause_an", an_a, exp_an(4, (k - 1) % 4));
            chk("pause_sseg", sseg_a, exp_seg(4, 6, (k - 1) % 4));
        end
        en = 1'b1;
        tick();                                 // counter 2 -> 3
        chk("resume_nostep", step_a, 0);
        chk("resume_pos", pos_a, 6);
        tick();                                 // counter wraps
        chk("resume_step", step_a, 1);
        chk("resume_pos5", pos_a, 5);

        // Reset while step_o is high at pos 5
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_step", step_a, 0);
        chk("mid_rst_pos", pos_a, 0);
        chk("mid_rst_an", an_a, 4'hF);
        chk("mid_rst_sseg", sseg_a, BLANK);
        dir = 1'b0;
        tick();
        chk("rst_hold_pos", pos_a, 0);
        rst = 1'b0;

        // Restart: full 4-cycle interval on dut_a; parameter sweep on dut_b
        for (int r = 1; r <= 40; r++) begin
            tick();
            if (r <= 8) begin
                chk("restart_step", step_a, (r % 4) == 0);
                chk("restart_pos", pos_a, r / 4);
                chk("restart_an", an_a, exp_an(4, (r - 1) % 4));
                chk("restart_sseg", sseg_a, exp_seg(4, (r - 1) / 4, (r - 1) % 4));
            end
            chk("b_pos", pos_b, r % 12);
            chk("b_step", step_b, 1);
            chk("b_an", an_b, exp_an(6, ((r - 1) / 3) % 6));
            chk("b_sseg", sseg_b, exp_seg(6, (r - 1) % 12, ((r - 1) / 3) % 6));
        end
        chk("restart_first_an", an_a, exp_an(4, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
